// File: rtl/ipsxe_fft_test_ctrl_if.sv
// Bundles the per-channel FFT/checker status lines and the sequencer's
// verdict outputs so the controller and its environment share one port.
interface ipsxe_fft_test_ctrl_if #(
   parameter int N_CH = 1
);
   logic              i_aclken;
   logic              i_start_test;
   logic [N_CH-1:0]   i_xk_tlast;
   logic [N_CH-1:0]   i_chk_finished;
   logic [N_CH-1:0]   i_err;
   logic [3*N_CH-1:0] i_alm;

   logic              o_start_pulse;
   logic              o_busy;
   logic              o_done;
   logic              o_pass;
   logic              o_timeout;
   logic [N_CH-1:0]   o_err_ch;
   logic              o_err;
   logic [15:0]       o_loop_cnt;

   // Environment side: drives button, enable and channel status, observes the verdict.
   modport master (
      output i_aclken, i_start_test, i_xk_tlast, i_chk_finished, i_err, i_alm,
      input  o_start_pulse, o_busy, o_done, o_pass, o_timeout, o_err_ch, o_err, o_loop_cnt
   );

   // Controller side.
   modport slave (
      input  i_aclken, i_start_test, i_xk_tlast, i_chk_finished, i_err, i_alm,
      output o_start_pulse, o_busy, o_done, o_pass, o_timeout, o_err_ch, o_err, o_loop_cnt
   );
endinterface

// File: rtl/ipsxe_fft_test_ctrl.sv
// Onboard test sequencer for multi-channel FFT demos: debounces the start
// button, fires one start strobe, supervises frame counts, a watchdog and
// sticky per-channel errors, then reports a pass/fail verdict. In loop mode
// it keeps re-running until the first failing run, counting passes.
module ipsxe_fft_test_ctrl #(
   parameter int N_CH           = 1,
   parameter int TEST_FRAME_NUM = 4,
   parameter int DB_CNT_MAX     = 2048,
   parameter int TIMEOUT_CYC    = 65536,
   parameter int LOOP_MODE      = 0
) (
   input logic                 i_clk,
   input logic                 i_rst,
   ipsxe_fft_test_ctrl_if.slave bus
);

   localparam int DBW = $clog2(DB_CNT_MAX);
   localparam int WDW = $clog2(TIMEOUT_CYC);
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CNT_MAX - 1);
   localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]     FRM_LAST = 8'(TEST_FRAME_NUM);

   typedef enum logic [2:0] {IDLE, DEBOUNCE, START, RUN, DONE} state_t;

   state_t          r_state;
   state_t          r_retState;
   logic [2:0]      r_sync;
   logic [DBW-1:0]  r_dbCnt;
   logic [WDW-1:0]  r_wdCnt;
   logic [7:0]      r_frameCnt [N_CH];
   logic            r_firstRun;
   logic            r_startPulse;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic            r_timeout;
   logic [N_CH-1:0] r_errCh;
   logic [15:0]     r_loopCnt;

   logic [N_CH-1:0] w_chErr;
   logic            w_allDone;
   logic            w_rise;
   logic            w_anyTlast;
   logic            w_loopAgain;

   assign w_rise      = r_sync[1] & ~r_sync[2];
   assign w_anyTlast  = |bus.i_xk_tlast;
   assign w_loopAgain = (LOOP_MODE != 0) && r_pass;

   // Per-channel error sources this cycle (checker error, any alarm bit, or a
   // tlast beyond the expected frame count) and the all-channels-finished test.
   always_comb begin
      w_chErr   = '0;
      w_allDone = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         w_chErr[c] = bus.i_err[c] | (|bus.i_alm[3*c +: 3]) |
                      (bus.i_xk_tlast[c] && (r_frameCnt[c] == FRM_LAST));
         w_allDone  = w_allDone & (r_frameCnt[c] == FRM_LAST) & bus.i_chk_finished[c];
      end
   end

   // Sequencer: synchroniser, debounce, start strobe, run supervision and verdict.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_retState   <= IDLE;
         r_sync       <= 3'b111;
         r_dbCnt      <= '0;
         r_wdCnt      <= '0;
         for (int c = 0; c < N_CH; c++) r_frameCnt[c] <= '0;
         r_firstRun   <= 1'b0;
         r_startPulse <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_timeout    <= 1'b0;
         r_errCh      <= '0;
         r_loopCnt    <= '0;
      end else if (bus.i_aclken) begin
         r_sync       <= {r_sync[1:0], bus.i_start_test};
         r_startPulse <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (r_state == DONE && w_loopAgain) begin
                  r_state      <= START;
                  r_startPulse <= 1'b1;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
               end else if (w_rise) begin
                  r_state    <= DEBOUNCE;
                  r_retState <= r_state;
                  r_dbCnt    <= DBW'(1);
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
               end
            end
            DEBOUNCE: begin
               if (!r_sync[2]) begin
                  r_state <= r_retState;
                  r_dbCnt <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= (r_retState == DONE);
               end else if (r_dbCnt == DB_LAST) begin
                  r_state      <= START;
                  r_dbCnt      <= '0;
                  r_startPulse <= 1'b1;
               end else begin
                  r_dbCnt <= r_dbCnt + DBW'(1);
               end
            end
            START: begin
               r_state    <= RUN;
               r_firstRun <= 1'b1;
               r_wdCnt    <= '0;
               for (int c = 0; c < N_CH; c++) r_frameCnt[c] <= '0;
               r_errCh    <= '0;
               r_timeout  <= 1'b0;
               r_pass     <= 1'b0;
            end
            RUN: begin
               r_firstRun <= 1'b0;
               r_errCh    <= r_errCh | w_chErr;
               for (int c = 0; c < N_CH; c++) begin
                  if (bus.i_xk_tlast[c] && (r_frameCnt[c] != FRM_LAST))
                     r_frameCnt[c] <= r_frameCnt[c] + 8'd1;
               end
               if (!r_firstRun && w_allDone) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= ~(|(r_errCh | w_chErr));
                  if (!(|(r_errCh | w_chErr)) && (r_loopCnt != 16'hFFFF))
                     r_loopCnt <= r_loopCnt + 16'd1;
               end else if (w_anyTlast) begin
                  r_wdCnt <= '0;
               end else if (r_wdCnt == WD_LAST) begin
                  r_timeout <= 1'b1;
                  r_state   <= DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_pass    <= 1'b0;
               end else begin
                  r_wdCnt <= r_wdCnt + WDW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.o_start_pulse = r_startPulse;
   assign bus.o_busy        = r_busy;
   assign bus.o_done        = r_done;
   assign bus.o_pass        = r_pass;
   assign bus.o_timeout     = r_timeout;
   assign bus.o_err_ch      = r_errCh;
   assign bus.o_err         = (|r_errCh) | r_timeout;
   assign bus.o_loop_cnt    = r_loopCnt;

endmodule

// File: tb/tb_ipsxe_fft_test_ctrl.sv
// Directed bench for ipsxe_fft_test_ctrl: a single-run instance (ifA) and a
// loop-mode instance (ifB), both two channels, four frames, 16-cycle debounce
// and a 100-cycle watchdog.
module tb_ipsxe_fft_test_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   ipsxe_fft_test_ctrl_if #(.N_CH(2)) ifA ();
   ipsxe_fft_test_ctrl_if #(.N_CH(2)) ifB ();

   ipsxe_fft_test_ctrl #(
      .N_CH(2), .TEST_FRAME_NUM(4), .DB_CNT_MAX(16), .TIMEOUT_CYC(100), .LOOP_MODE(0)
   ) dutA (
      .i_clk(clock), .i_rst(reset), .bus(ifA.slave)
   );

   ipsxe_fft_test_ctrl #(
      .N_CH(2), .TEST_FRAME_NUM(4), .DB_CNT_MAX(16), .TIMEOUT_CYC(100), .LOOP_MODE(1)
   ) dutB (
      .i_clk(clock), .i_rst(reset), .bus(ifB.slave)
   );

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Press A's button from the current cycle (cycle 1) for 'hold' cycles,
   // optionally disabling the clock enable over cycles [gf, gf+gl); reports
   // how many cycles o_start_pulse was seen high and the first such cycle.
   task automatic applyStimulus(input int hold, input int gf, input int gl,
                                output int pulses, output int first);
      pulses = 0;
      first  = 0;
      ifA.i_chk_finished = 2'b00;
      ifA.i_start_test   = 1'b1;
      for (int cyc = 1; cyc <= hold; cyc++) begin
         ifA.i_aclken = !(cyc >= gf && cyc < gf + gl);
         @(negedge clock);
         if (ifA.o_start_pulse) begin
            pulses++;
            if (first == 0) first = cyc;
         end
         @(posedge clock);
         #1;
      end
      ifA.i_aclken = 1'b1;
   endtask

   // Pulse tlast on the masked channels of A, n times, one frame every two cycles.
   task automatic sendFramesA(input logic [1:0] mask, input int n);
      repeat (n) begin
         ifA.i_xk_tlast = mask;
         tick(1);
         ifA.i_xk_tlast = 2'b00;
         tick(1);
      end
   endtask

   // Wait (bounded) for A's o_done; returns at the falling edge where it was seen.
   task automatic waitDoneA(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clock);
         if (ifA.o_done) begin
            ok = 1'b1;
            break;
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset;
      logic [23:0] va, vb;
      reset = 1'b1;
      tick(3);
      @(negedge clock);
      va = {ifA.o_start_pulse, ifA.o_busy, ifA.o_done, ifA.o_pass, ifA.o_timeout,
            ifA.o_err_ch, ifA.o_err, ifA.o_loop_cnt};
      vb = {ifB.o_start_pulse, ifB.o_busy, ifB.o_done, ifB.o_pass, ifB.o_timeout,
            ifB.o_err_ch, ifB.o_err, ifB.o_loop_cnt};
      checks++;
      if (va !== 24'h0) begin
         errors++;
         $display("[TB] FAIL resetA: outputs=%h expected 000000", va);
      end
      checks++;
      if (vb !== 24'h0) begin
         errors++;
         $display("[TB] FAIL resetB: outputs=%h expected 000000", vb);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      tick(3);
   endtask

   task automatic test_clean_run;
      int pulses, first;
      bit ok;
      applyStimulus(40, 0, 0, pulses, first);
      ifA.i_start_test = 1'b0;
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("[TB] FAIL clean_pulses: got %0d expected 1", pulses);
      end
      checks++;
      if (first !== 19) begin
         errors++;
         $display("[TB] FAIL clean_latency: pulse in cycle %0d expected 19", first);
      end
      sendFramesA(2'b11, 4);
      tick(3);
      checks++;
      if (ifA.o_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clean_wait_checker: o_done=%b expected 0", ifA.o_done);
      end
      ifA.i_chk_finished = 2'b11;
      waitDoneA(10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL clean_done: o_done never rose, expected 1");
      end
      checks++;
      if ({ifA.o_pass, ifA.o_err, ifA.o_err_ch, ifA.o_busy} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL clean_verdict: pass/err/err_ch/busy=%b expected 10000",
                  {ifA.o_pass, ifA.o_err, ifA.o_err_ch, ifA.o_busy});
      end
      checks++;
      if (ifA.o_loop_cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL clean_loop_cnt: got %0d expected 1", ifA.o_loop_cnt);
      end
      tick(1);
   endtask

   task automatic test_bounce;
      int pulses, first;
      pulses = 0;
      ifA.i_chk_finished = 2'b00;
      ifA.i_start_test   = 1'b1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (cyc == 10) ifA.i_start_test = 1'b0;
         @(negedge clock);
         if (ifA.o_start_pulse) pulses++;
         @(posedge clock);
         #1;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("[TB] FAIL bounce_first_burst: pulses=%0d expected 0", pulses);
      end
      checks++;
      if ({ifA.o_done, ifA.o_pass, ifA.o_busy} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL bounce_return_done: done/pass/busy=%b expected 110",
                  {ifA.o_done, ifA.o_pass, ifA.o_busy});
      end
      applyStimulus(30, 0, 0, pulses, first);
      ifA.i_start_test = 1'b0;
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("[TB] FAIL bounce_second_burst: pulses=%0d expected 1", pulses);
      end
   endtask

   // Continues the run started by the second bounce burst.
   task automatic test_channel_error;
      bit ok;
      sendFramesA(2'b11, 2);
      ifA.i_alm = 6'b010000;
      tick(1);
      ifA.i_alm = 6'b000000;
      tick(1);
      sendFramesA(2'b11, 2);
      ifA.i_chk_finished = 2'b11;
      waitDoneA(10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL chan_err_done: o_done never rose, expected 1");
      end
      checks++;
      if ({ifA.o_err_ch, ifA.o_pass, ifA.o_err} !== 4'b1001) begin
         errors++;
         $display("[TB] FAIL chan_err_verdict: err_ch/pass/err=%b expected 1001",
                  {ifA.o_err_ch, ifA.o_pass, ifA.o_err});
      end
      checks++;
      if (ifA.o_loop_cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL chan_err_loop_cnt: got %0d expected 1", ifA.o_loop_cnt);
      end
      tick(5);
      ifA.i_err = 2'b01;
      tick(1);
      ifA.i_err = 2'b00;
      tick(2);
      checks++;
      if ({ifA.o_err_ch, ifA.o_pass, ifA.o_done} !== 4'b1001) begin
         errors++;
         $display("[TB] FAIL chan_err_sticky: err_ch/pass/done=%b expected 1001",
                  {ifA.o_err_ch, ifA.o_pass, ifA.o_done});
      end
   endtask

   task automatic test_watchdog;
      int pulses, first, n;
      applyStimulus(25, 0, 0, pulses, first);
      ifA.i_start_test = 1'b0;
      checks++;
      if ({pulses[1:0], ifA.o_err_ch, ifA.o_pass, ifA.o_timeout, ifA.o_busy} !== 7'b0100001) begin
         errors++;
         $display("[TB] FAIL wd_cleared_at_start: pulses/err_ch/pass/timeout/busy=%b expected 0100001",
                  {pulses[1:0], ifA.o_err_ch, ifA.o_pass, ifA.o_timeout, ifA.o_busy});
      end
      sendFramesA(2'b11, 1);
      ifA.i_xk_tlast = 2'b01;
      @(posedge clock);
      #1 ifA.i_xk_tlast = 2'b00;
      n = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clock);
         if (ifA.o_timeout) break;
         @(posedge clock);
         #1 n++;
      end
      checks++;
      if (n !== 100) begin
         errors++;
         $display("[TB] FAIL wd_latency: timeout after %0d cycles expected 100", n);
      end
      checks++;
      if ({ifA.o_timeout, ifA.o_done, ifA.o_pass, ifA.o_err, ifA.o_err_ch} !== 6'b110100) begin
         errors++;
         $display("[TB] FAIL wd_verdict: timeout/done/pass/err/err_ch=%b expected 110100",
                  {ifA.o_timeout, ifA.o_done, ifA.o_pass, ifA.o_err, ifA.o_err_ch});
      end
      tick(1);
   endtask

   task automatic test_loop_mode;
      bit ok;
      int pulses;
      ifB.i_chk_finished = 2'b11;
      ifB.i_start_test   = 1'b1;
      tick(1);
      for (int r = 0; r < 4; r++) begin
         ok = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (ifB.o_start_pulse) begin
               ok = 1'b1;
               break;
            end
            @(posedge clock);
            #1;
         end
         checks++;
         if (!ok) begin
            errors++;
            $display("[TB] FAIL loop_start_%0d: no o_start_pulse, expected 1", r);
         end
         tick(1);
         if (r < 3) begin
            repeat (4) begin
               ifB.i_xk_tlast = 2'b11; tick(1);
               ifB.i_xk_tlast = 2'b00; tick(1);
            end
         end else begin
            repeat (5) begin
               ifB.i_xk_tlast = 2'b01; tick(1);
               ifB.i_xk_tlast = 2'b00; tick(1);
            end
            repeat (4) begin
               ifB.i_xk_tlast = 2'b10; tick(1);
               ifB.i_xk_tlast = 2'b00; tick(1);
            end
         end
         ok = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (ifB.o_done) begin
               ok = 1'b1;
               break;
            end
            @(posedge clock);
            #1;
         end
         checks++;
         if (!ok || ifB.o_pass !== (r < 3) || ifB.o_loop_cnt !== 16'((r < 3) ? r + 1 : 3)) begin
            errors++;
            $display("[TB] FAIL loop_run_%0d: done=%b pass=%b loop_cnt=%0d expected 1 %0d %0d",
                     r, ok, ifB.o_pass, ifB.o_loop_cnt, (r < 3), (r < 3) ? r + 1 : 3);
         end
      end
      checks++;
      if (ifB.o_err_ch !== 2'b01) begin
         errors++;
         $display("[TB] FAIL loop_overflow_err: err_ch=%b expected 01", ifB.o_err_ch);
      end
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (ifB.o_start_pulse) pulses++;
      end
      checks++;
      if (pulses !== 0 || ifB.o_done !== 1'b1 || ifB.o_loop_cnt !== 16'd3) begin
         errors++;
         $display("[TB] FAIL loop_stays_done: pulses=%0d done=%b loop_cnt=%0d expected 0 1 3",
                  pulses, ifB.o_done, ifB.o_loop_cnt);
      end
      ifB.i_start_test = 1'b0;
      tick(1);
   endtask

   task automatic test_reset_mid_run;
      int pulses, first;
      logic [23:0] va;
      applyStimulus(25, 0, 0, pulses, first);
      sendFramesA(2'b01, 1);
      reset = 1'b1;
      @(negedge clock);
      va = {ifA.o_start_pulse, ifA.o_busy, ifA.o_done, ifA.o_pass, ifA.o_timeout,
            ifA.o_err_ch, ifA.o_err, ifA.o_loop_cnt};
      checks++;
      if (va !== 24'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid_run: outputs=%h expected 000000", va);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (ifA.o_start_pulse) pulses++;
         @(posedge clock);
         #1;
      end
      checks++;
      if (pulses !== 0 || ifA.o_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL held_through_reset: pulses=%0d busy=%b expected 0 0",
                  pulses, ifA.o_busy);
      end
   endtask

   task automatic test_enable;
      int pulses, first;
      ifA.i_start_test = 1'b0;
      tick(6);
      applyStimulus(35, 5, 5, pulses, first);
      ifA.i_start_test = 1'b0;
      checks++;
      if (pulses !== 1 || first !== 24) begin
         errors++;
         $display("[TB] FAIL enable_stretch: pulses=%0d cycle=%0d expected 1 24", pulses, first);
      end
      checks++;
      if (ifA.o_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL enable_busy: busy=%b expected 1", ifA.o_busy);
      end
   endtask

   // Safety net in case a scenario stalls the simulation.
   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   // Scenario sequence and summary.
   initial begin
      ifA.i_aclken = 1'b1; ifA.i_start_test = 1'b0; ifA.i_xk_tlast = '0;
      ifA.i_chk_finished = '0; ifA.i_err = '0; ifA.i_alm = '0;
      ifB.i_aclken = 1'b1; ifB.i_start_test = 1'b0; ifB.i_xk_tlast = '0;
      ifB.i_chk_finished = '0; ifB.i_err = '0; ifB.i_alm = '0;
      test_reset();
      test_clean_run();
      test_bounce();
      test_channel_error();
      test_watchdog();
      test_loop_mode();
      test_reset_mid_run();
      test_enable();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
